ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu16_core.sv | 71 +++++++
 rtl/ex_stage.sv | 85 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, operation encodings and a bit-reverse helper.
// Used by the decode stage and the execute stage.
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } alu_op_e;

  function automatic logic [ALU_W-1:0] bit_rev(input logic [ALU_W-1:0] v);
    logic [ALU_W-1:0] r;
    for (int i = 0; i < ALU_W; i++) r[i] = v[ALU_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/alu16_core.sv
// Combinational 16-bit ALU: result, zero and carry from op, a and b.
// All shifts share one 4-stage right barrel shifter; SLL goes through it bit-reversed.
module alu16_core
  import alu_pkg::*;
(
  input  logic [2:0]       i_op,
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  output logic [ALU_W-1:0] o_result,
  output logic             o_zero,
  output logic             o_carry
);

  alu_op_e          w_op;
  logic [3:0]       w_n;
  logic [ALU_W:0]   w_sum;
  logic [ALU_W:0]   w_diff;
  logic             w_fill;
  logic [ALU_W-1:0] w_src;
  logic [ALU_W:0]   w_st0;
  logic [ALU_W:0]   w_st1;
  logic [ALU_W:0]   w_st2;
  logic [ALU_W:0]   w_st3;
  logic [ALU_W:0]   w_st4;
  logic [ALU_W-1:0] w_shr;

  assign w_op   = alu_op_e'(i_op);
  assign w_n    = i_b[3:0];
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // A guard bit below the LSB collects the last bit shifted out.
  assign w_fill = (w_op == OP_SRA) & i_a[ALU_W-1];
  assign w_src  = (w_op == OP_SLL) ? bit_rev(i_a) : i_a;
  assign w_st0  = {w_src, 1'b0};
  assign w_st1  = w_n[0] ? {{1{w_fill}}, w_st0[ALU_W:1]} : w_st0;
  assign w_st2  = w_n[1] ? {{2{w_fill}}, w_st1[ALU_W:2]} : w_st1;
  assign w_st3  = w_n[2] ? {{4{w_fill}}, w_st2[ALU_W:4]} : w_st2;
  assign w_st4  = w_n[3] ? {{8{w_fill}}, w_st3[ALU_W:8]} : w_st3;
  assign w_shr  = w_st4[ALU_W:1];

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (w_op)
      OP_ADD: begin
        o_result = w_sum[ALU_W-1:0];
        o_carry  = w_sum[ALU_W];
      end
      OP_SUB: begin
        o_result = w_diff[ALU_W-1:0];
        o_carry  = w_diff[ALU_W];
      end
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_SLL: begin
        o_result = bit_rev(w_shr);
        o_carry  = w_st4[0];
      end
      OP_SRL, OP_SRA: begin
        o_result = w_shr;
        o_carry  = w_st4[0];
      end
      default: ;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: one-deep valid/ready pipeline register around alu16_core.
// Flush discards the held result and blocks acceptance in the same cycle.
module ex_stage
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_rd,
  input  logic         in_we,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [2:0]   out_rd,
  output logic         out_we,
  output logic         out_zero,
  output logic         out_carry
);

  logic         r_valid;
  logic [W-1:0] r_result;
  logic [2:0]   r_rd;
  logic         r_we;
  logic         r_zero;
  logic         r_carry;

  logic         w_accept;
  logic [W-1:0] w_result;
  logic         w_zero;
  logic         w_carry;

  alu16_core u_alu (
    .i_op     (in_op),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_result (w_result),
    .o_zero   (w_zero),
    .o_carry  (w_carry)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
      r_we     <= 1'b0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      if (flush)
        r_valid <= 1'b0;
      else if (w_accept)
        r_valid <= 1'b1;
      else if (out_ready)
        r_valid <= 1'b0;

      // Data registers only move on acceptance so they stay stable otherwise.
      if (w_accept) begin
        r_result <= w_result;
        r_rd     <= in_rd;
        r_we     <= in_we;
        r_zero   <= w_zero;
        r_carry  <= w_carry;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_rd     = r_rd;
  assign out_we     = r_we;
  assign out_zero   = r_zero;
  assign out_carry  = r_carry;

endmodule
